dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequencer and arbiter for the single-port, word-wide data memory. It sits between the MEM pipeline stage and the RAM, and also serves a word-only debug/loader port. It converts byte and halfword loads and stores into word accesses, using read-modify-write for sub-word stores. It stalls the pipeline for multi-cycle accesses and grants the debug port only when the pipeline is idle.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, word width (fixed at 32 for sub-word lanes)
- NUM_LOCS, 64, RAM depth in words; IDX = $clog2(NUM_LOCS)

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  synchronous active-low reset
- mem_read, mem_write  in  1 each  MEM-stage request; held stable while mem_stall=1
- load_store_type  in  2  00 byte, 01 half, 10 word, 11 treated as word
- load_unsigned  in  1  zero-extend loads when 1
- mem_addr  in  ADDR_WIDTH  byte address
- mem_write_data  in  DATA_WIDTH  store data; sub-word taken from low bits
- mem_read_data  out  DATA_WIDTH  extended load result
- mem_stall  out  1  freeze pipeline this cycle
- dbg_req, dbg_we  in  1 each  debug request / write
- dbg_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- dbg_wdata  in  DATA_WIDTH  debug write word
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  dbg_rdata valid, one-cycle pulse
- dbg_rdata  out  DATA_WIDTH  debug read word
- ram_en, ram_we  out  1 each  RAM access / write
- ram_addr  out  IDX  word index = addr[IDX+1:2] (upper bits dropped, wraps)
- ram_wdata  out  DATA_WIDTH  RAM write word
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en && !ram_we

## Operation
- Little-endian lanes. Byte lane = addr[1:0]. Half lane = addr[1], addr[0] ignored. Word ignores addr[1:0].
- If mem_read and mem_write are both high, it is a write.
- States: IDLE, P_LD, P_RMW, D_LD.
- IDLE, pipeline load: issue RAM read; mem_stall=1; go to P_LD.
- IDLE, word store: RAM write in the same cycle; mem_stall=0; stay IDLE.
- IDLE, byte/half store: issue RAM read; mem_stall=1; go to P_RMW.
- IDLE, no pipeline request, dbg_req=1: dbg_gnt=1.
  - Debug write: RAM write this cycle; stay IDLE.
  - Debug read: issue read; go to D_LD.
- P_LD: extract the lane from ram_rdata and sign/zero-extend. Drive mem_read_data combinationally and capture it in the hold register. mem_stall=0. Go to IDLE.
- P_RMW: merge the store lane into ram_rdata and write the merged word. Other bytes are unchanged. mem_stall=0. Go to IDLE.
- D_LD: dbg_rdata <= ram_rdata (registered); dbg_rvalid=1. If a pipeline request is present, mem_stall=1 and the request is issued next cycle from IDLE. dbg_gnt=0. Go to IDLE.
- Priority: pipeline always beats debug in IDLE. An ungranted dbg_req waits; debug holds its inputs until dbg_gnt.
- Outside P_LD, mem_read_data shows the hold register (last completed load).
- ram_en=0 whenever no access is issued. ram_wdata is don't-care when ram_we=0.

## Timing
- Reset (rstn=0 at edge) puts state in IDLE and clears the hold register, dbg_rdata and dbg_rvalid to 0.
- While rstn=0: mem_stall, dbg_gnt, ram_en and ram_we are forced 0.
- Reset during P_LD, P_RMW or D_LD abandons the access; no RAM write, no dbg_rvalid.
- Latency from the cycle the request is seen in IDLE:
  - load: 2 cycles, 1 stall cycle
  - sub-word store: 2 cycles, 1 stall cycle, RAM write in the second
  - word store: 1 cycle, no stall
  - debug read: gnt in cycle 0, rvalid in cycle 1
  - a pipeline request arriving during D_LD gets 1 extra stall cycle
- Back-to-back pipeline loads: P_LD → IDLE → P_LD. No bubble beyond the 1 stall per load.
- Address wrap: a byte address ≥ 4·NUM_LOCS aliases modulo the RAM depth.

## Test plan
- Reset, then a word store at 0x08 of 0xDEADBEEF, then a byte load (signed) at 0x0B → 0xFFFFFFDE. mem_stall is high exactly 1 cycle for the load and 0 for the store.
- Half store of 0x1234 at 0x0A over 0xDEADBEEF, then a word load at 0x08 → 0x1234BEEF. Lanes 0–1 unchanged; the RAM write occurs in the P_RMW cycle.
- Byte load at 0x09 with load_unsigned=1 over 0x1234BEEF → 0x000000BE. With load_unsigned=0 → 0xFFFFFFBE.
- dbg_req read at 0x08 while the pipeline is idle → dbg_gnt that cycle, dbg_rvalid with 0x1234BEEF next cycle. A pipeline load raised in the D_LD cycle sees 2 stall cycles.
- dbg_req held while the pipeline issues 3 consecutive loads → dbg_gnt stays 0 until the first IDLE cycle with no pipeline request. A store at address 0x100 (NUM_LOCS=64) aliases to word 0.
- Assert rstn=0 in the P_RMW cycle → no RAM write, state IDLE, mem_read_data=0, dbg_rvalid=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter: word-RAM sequencer for sub-word pipeline access + debug port
// Rev 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LOCS   = 64,
  localparam int IDX       = $clog2(NUM_LOCS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            load_store_type,
  input  logic                  load_unsigned,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [IDX-1:0]        ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_P_LD  = 2'd1,
    S_P_RMW = 2'd2,
    S_D_LD  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_dbg_rdata;
  logic                  r_dbg_rvalid;

  logic                  w_pipe_req;
  logic                  w_word_op;
  logic [IDX-1:0]        w_mem_idx;
  logic [IDX-1:0]        w_dbg_idx;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_val;
  logic [DATA_WIDTH-1:0] w_merge;
  logic                  w_unused_addr_bits;

  assign w_pipe_req = mem_read | mem_write;
  assign w_word_op  = load_store_type[1];
  assign w_mem_idx  = mem_addr[IDX+1:2];
  assign w_dbg_idx  = dbg_addr[IDX+1:2];

  // Upper address bits alias onto the RAM depth; debug is word-only.
  assign w_unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:IDX+2],
                                dbg_addr[ADDR_WIDTH-1:IDX+2], dbg_addr[1:0]};

  always_comb begin
    case (mem_addr[1:0])
      2'd0:    w_byte = ram_rdata[7:0];
      2'd1:    w_byte = ram_rdata[15:8];
      2'd2:    w_byte = ram_rdata[23:16];
      default: w_byte = ram_rdata[31:24];
    endcase
    w_half = mem_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (load_store_type)
      2'b00:   w_load_val = {{(DATA_WIDTH-8){w_byte[7] & ~load_unsigned}}, w_byte};
      2'b01:   w_load_val = {{(DATA_WIDTH-16){w_half[15] & ~load_unsigned}}, w_half};
      default: w_load_val = ram_rdata;
    endcase
  end

  always_comb begin
    w_merge = ram_rdata;
    if (load_store_type == 2'b00) begin
      case (mem_addr[1:0])
        2'd0:    w_merge[7:0]   = mem_write_data[7:0];
        2'd1:    w_merge[15:8]  = mem_write_data[7:0];
        2'd2:    w_merge[23:16] = mem_write_data[7:0];
        default: w_merge[31:24] = mem_write_data[7:0];
      endcase
    end else if (load_store_type == 2'b01) begin
      if (mem_addr[1]) w_merge[31:16] = mem_write_data[15:0];
      else             w_merge[15:0]  = mem_write_data[15:0];
    end
  end

  always_comb begin
    mem_stall     = 1'b0;
    dbg_gnt       = 1'b0;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = w_mem_idx;
    ram_wdata     = mem_write_data;
    mem_read_data = r_hold;
    w_state_next  = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pipe_req) begin
          ram_en = 1'b1;
          if (mem_write && w_word_op) begin
            ram_we = 1'b1;
          end else begin
            mem_stall    = 1'b1;
            w_state_next = mem_write ? S_P_RMW : S_P_LD;
          end
        end else if (dbg_req) begin
          dbg_gnt   = 1'b1;
          ram_en    = 1'b1;
          ram_we    = dbg_we;
          ram_addr  = w_dbg_idx;
          ram_wdata = dbg_wdata;
          if (!dbg_we) w_state_next = S_D_LD;
        end
      end
      S_P_LD: begin
        mem_read_data = w_load_val;
        w_state_next  = S_IDLE;
      end
      S_P_RMW: begin
        ram_en       = 1'b1;
        ram_we       = 1'b1;
        ram_wdata    = w_merge;
        w_state_next = S_IDLE;
      end
      S_D_LD: begin
        // RAM is busy returning debug data; a new pipeline request waits one cycle.
        mem_stall    = w_pipe_req;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (!rstn) begin
      mem_stall = 1'b0;
      dbg_gnt   = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_dbg_rdata  <= '0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      // Pulse and data are registered together so they always line up.
      r_dbg_rvalid <= (r_state == S_D_LD);
      if (r_state == S_D_LD) r_dbg_rdata <= ram_rdata;
      if (r_state == S_P_LD) r_hold <= w_load_val;
    end
  end

  assign dbg_rvalid = r_dbg_rvalid;
  assign dbg_rdata  = r_dbg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter: randomized bench against a transaction-level memory model
// Rev 1.0
// ============================================================================
module tb_dmem_arbiter;
  localparam int NL = 64;
  localparam int IX = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read, mem_write, load_unsigned;
  logic [1:0]  load_store_type;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_stall;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        ram_en, ram_we;
  logic [IX-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LOCS(NL)) dut (
    .clk(clk), .rstn(rstn),
    .mem_read(mem_read), .mem_write(mem_write),
    .load_store_type(load_store_type), .load_unsigned(load_unsigned),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_stall(mem_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Simple synchronous RAM: read data valid the cycle after the read.
  logic [31:0] mem [NL];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [NL];
  logic [31:0] last_load, last_dbg;
  bit          rv_next;
  bit          pd_we;
  logic [31:0] pd_addr, pd_wd;

  // Expected outputs for the current cycle
  bit          chk_on, e_stall, e_gnt, e_en, e_we, e_rvalid;
  logic [IX-1:0] e_addr;
  logic [31:0] e_wdata, e_mrd, e_drd;
  bit          lit_on, lit_dbg, sweep_on;
  logic [31:0] lit_val;
  string       lit_name;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: dut=%h expected=%h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("mem_stall", 32'(mem_stall), 32'(e_stall));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(e_gnt));
      chk("ram_en", 32'(ram_en), 32'(e_en));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      if (e_en) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_we) chk("ram_wdata", ram_wdata, e_wdata);
      chk("mem_read_data", mem_read_data, e_mrd);
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e_rvalid));
      chk("dbg_rdata", dbg_rdata, e_drd);
    end
    if (lit_on) chk(lit_name, lit_dbg ? dbg_rdata : mem_read_data, lit_val);
    if (sweep_on) for (int i = 0; i < NL; i++) chk("ram_contents", mem[i], ref_mem[i]);
  end

  function automatic logic [IX-1:0] widx(input logic [31:0] a);
    return IX'((a / 4) % NL);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] t, input bit u);
    logic [31:0] v;
    if (t == 2'b00) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!u && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (t == 2'b01) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] a,
                                              input logic [1:0] t, input logic [31:0] d);
    logic [31:0] sh, mask;
    if (t == 2'b00) begin
      sh = 8 * (a % 4);
      mask = 32'hFF << sh;
      return (old & ~mask) | ((d & 32'hFF) << sh);
    end else if (t == 2'b01) begin
      sh = 16 * ((a / 2) % 2);
      mask = 32'hFFFF << sh;
      return (old & ~mask) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    e_stall = 0; e_gnt = 0; e_en = 0; e_we = 0;
    e_addr = '0; e_wdata = '0;
    e_rvalid = rv_next; rv_next = 0;
    e_mrd = last_load; e_drd = last_dbg;
    lit_on = 0; sweep_on = 0;
  endtask

  task automatic idle_cycle();
    begin_cycle();
    mem_read = 0; mem_write = 0; dbg_req = 0;
    mem_addr = $urandom; dbg_addr = $urandom; dbg_we = 1'($urandom_range(0, 1));
  endtask

  task automatic lit(input string nm, input bit is_dbg, input logic [31:0] v);
    idle_cycle();
    lit_on = 1; lit_name = nm; lit_dbg = is_dbg; lit_val = v;
  endtask

  task automatic pipe_op(input bit ld, input logic [1:0] t, input bit u,
                         input logic [31:0] a, input logic [31:0] wd, input bit keep_dbg);
    logic [31:0] nv;
    begin_cycle();
    mem_read = ld | 1'($urandom_range(0, 1));
    mem_write = !ld;
    load_store_type = t; load_unsigned = u; mem_addr = a; mem_write_data = wd;
    if (keep_dbg) begin
      dbg_req = 1; dbg_we = pd_we; dbg_addr = pd_addr; dbg_wdata = pd_wd;
    end else begin
      dbg_req = 0;
    end
    e_en = 1; e_addr = widx(a);
    if (!ld && t[1]) begin
      e_we = 1; e_wdata = wd; ref_mem[widx(a)] = wd;
    end else begin
      e_stall = 1;
      begin_cycle();
      if (ld) begin
        nv = model_load(ref_mem[widx(a)], a, t, u);
        e_mrd = nv; last_load = nv;
      end else begin
        nv = model_merge(ref_mem[widx(a)], a, t, wd);
        e_en = 1; e_we = 1; e_addr = widx(a); e_wdata = nv;
        ref_mem[widx(a)] = nv;
      end
    end
  endtask

  task automatic dbg_op(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input bit follow, input logic [31:0] fa, input logic [1:0] ft, input bit fu);
    begin_cycle();
    mem_read = 0; mem_write = 0;
    dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    e_gnt = 1; e_en = 1; e_we = we; e_addr = widx(a);
    if (we) begin
      e_wdata = wd; ref_mem[widx(a)] = wd;
    end else begin
      begin_cycle();
      dbg_req = 0;
      rv_next = 1; last_dbg = ref_mem[widx(a)];
      if (follow) begin
        mem_read = 1; mem_write = 0; load_store_type = ft; load_unsigned = fu; mem_addr = fa;
        e_stall = 1;
        pipe_op(1, ft, fu, fa, 32'h0, 0);
      end
    end
  endtask

  task automatic reset_in_rmw(input logic [31:0] a, input logic [31:0] wd);
    begin_cycle();
    mem_read = 0; mem_write = 1; load_store_type = 2'b01; mem_addr = a; mem_write_data = wd;
    dbg_req = 0;
    e_stall = 1; e_en = 1; e_addr = widx(a);
    begin_cycle();
    rstn = 0;
    last_load = 0; last_dbg = 0; rv_next = 0;
    begin_cycle();
    rstn = 1; mem_write = 0;
    lit_on = 1; lit_name = "rst_rmw_mrd"; lit_dbg = 0; lit_val = 32'h0;
  endtask

  task automatic reset_in_dld(input logic [31:0] a);
    begin_cycle();
    mem_read = 0; mem_write = 0; dbg_req = 1; dbg_we = 0; dbg_addr = a;
    e_gnt = 1; e_en = 1; e_addr = widx(a);
    begin_cycle();
    dbg_req = 0; rstn = 0;
    last_load = 0; last_dbg = 0; rv_next = 0;
    begin_cycle();
    rstn = 1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
  endfunction

  initial begin
    rstn = 0; mem_read = 0; mem_write = 0; load_store_type = 0; load_unsigned = 0;
    mem_addr = 0; mem_write_data = 0; dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    chk_on = 0; lit_on = 0; sweep_on = 0; rv_next = 0;
    last_load = 0; last_dbg = 0; lit_val = 0; lit_dbg = 0; lit_name = "";
    for (int i = 0; i < NL; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    begin_cycle();
    chk_on = 1;
    lit_on = 1; lit_name = "reset_mrd"; lit_dbg = 0; lit_val = 32'h0;
    begin_cycle();
    rstn = 1;

    pipe_op(0, 2'b10, 0, 32'h08, 32'hDEADBEEF, 0);
    pipe_op(1, 2'b00, 0, 32'h0B, 32'h0, 0);
    lit("byte_signed_0B", 0, 32'hFFFFFFDE);
    pipe_op(0, 2'b01, 0, 32'h0A, 32'hABCD1234, 0);
    pipe_op(1, 2'b10, 0, 32'h08, 32'h0, 0);
    lit("half_rmw_word", 0, 32'h1234BEEF);
    pipe_op(1, 2'b00, 1, 32'h09, 32'h0, 0);
    lit("byte_unsigned_09", 0, 32'h000000BE);
    pipe_op(1, 2'b00, 0, 32'h09, 32'h0, 0);
    lit("byte_signed_09", 0, 32'hFFFFFFBE);
    dbg_op(0, 32'h08, 32'h0, 1, 32'h08, 2'b11, 0);
    lit("dbg_read_08", 1, 32'h1234BEEF);

    pd_we = 1; pd_addr = 32'h43; pd_wd = 32'h55AA55AA;
    pipe_op(1, 2'b10, 0, 32'h08, 32'h0, 1);
    pipe_op(1, 2'b01, 1, 32'h0A, 32'h0, 1);
    pipe_op(1, 2'b00, 0, 32'h0B, 32'h0, 1);
    dbg_op(pd_we, pd_addr, pd_wd, 0, 32'h0, 2'b00, 0);
    pipe_op(1, 2'b10, 0, 32'h40, 32'h0, 0);
    lit("dbg_write_40", 0, 32'h55AA55AA);

    pipe_op(0, 2'b10, 0, 32'h100, 32'hCAFEF00D, 0);
    pipe_op(1, 2'b10, 0, 32'h000, 32'h0, 0);
    lit("alias_0x100", 0, 32'hCAFEF00D);

    reset_in_rmw(32'h02, 32'h9999);
    pipe_op(1, 2'b10, 0, 32'h000, 32'h0, 0);
    lit("rmw_abandoned", 0, 32'hCAFEF00D);
    reset_in_dld(32'h08);
    idle_cycle();

    repeat (400) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        pipe_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                rnd_addr(), $urandom, 0);
      end else if (r == 5) begin
        pd_we = 1'($urandom_range(0, 1)); pd_addr = rnd_addr(); pd_wd = $urandom;
        repeat ($urandom_range(1, 3))
          pipe_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  rnd_addr(), $urandom, 1);
        dbg_op(pd_we, pd_addr, pd_wd, 0, 32'h0, 2'b00, 0);
      end else if (r <= 7) begin
        dbg_op(1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'($urandom_range(0, 1)),
               rnd_addr(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end else begin
        idle_cycle();
      end
    end

    idle_cycle();
    idle_cycle();
    sweep_on = 1;
    begin_cycle();
    chk_on = 0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
